// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : AXI4 encodings, the write-stage FSM state encoding and the
//                stream FIFO entry layout shared by the stream/memory stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [2:0] SIZE_8B         = 3'b011;
    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

    // Write-stage FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    // One buffered stream beat: data, byte enables, end-of-packet flag
    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
    } fifo_entry_t;

endpackage : axi_pkg
`default_nettype wire

// File: rtl/axis_to_axifull_wr_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_to_axifull_wr_if
//  Description : Stream input plus AXI4 write channels of the stream-to-memory
//                write stage. "master" is the write stage's view, "slave" is
//                the view of the stream source / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_to_axifull_wr_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    // AXI-Stream input
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic                    s_axis_tlast;
    logic                    s_axis_tuser;
    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic [DATA_WIDTH/8-1:0] s_axis_tkeep;

    // Write address channel
    logic [ID_WIDTH-1:0]     M_AXI_AWID;
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [7:0]              M_AXI_AWLEN;
    logic [2:0]              M_AXI_AWSIZE;
    logic [1:0]              M_AXI_AWBURST;
    logic                    M_AXI_AWLOCK;
    logic [3:0]              M_AXI_AWCACHE;
    logic [3:0]              M_AXI_AWPROT;
    logic [3:0]              M_AXI_AWQOS;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;

    // Write data channel
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WLAST;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;

    // Write response channel
    logic [ID_WIDTH-1:0]     M_AXI_BID;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
        output M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
        input  M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY
    );

endinterface : axis_to_axifull_wr_if
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_fwft
//  Description : Single-clock first-word-fall-through FIFO with occupancy
//                count. The head entry is visible on o_rd_data whenever
//                o_empty is low. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_wr_en,
    input  wire logic [WIDTH-1:0]   i_wr_data,
    output logic                    o_full,
    input  wire logic               i_rd_en,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int              PW      = $clog2(DEPTH);
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q,  count_d;
    logic             push, pop;

    assign o_full    = (count_q == DEPTH_C);
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_rd_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy; push and pop together leave count unchanged
    always_comb begin
        push     = i_wr_en && !o_full;
        pop      = i_rd_en && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset empties the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_wr_data;
    end

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/axis_to_axifull_wr.sv
`default_nettype none
// ============================================================================
//  Module      : axis_to_axifull_wr
//  Description : Buffers a 64-bit AXI-Stream and writes it to a circular memory
//                region as single-outstanding AXI4 INCR bursts. Every burst
//                owns a full slot of BURST_LEN*8 bytes so the read stage can
//                fetch whole slots back; tlast only flushes partial bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_to_axifull_wr
    import axi_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h00000000,
    parameter logic [31:0] C_REGION_BYTES             = 32'h00100000,
    parameter int          C_M_AXI_BURST_LEN          = 16,
    parameter int          C_M_AXI_ID_WIDTH           = 1,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 64
) (
    input  wire logic                        M_AXI_ACLK,
    input  wire logic                        M_AXI_ARESET,
    input  wire logic                        INIT_AXI_TXN,
    axis_to_axifull_wr_if.master             m_axi,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]    wr_ptr,
    output logic                             burst_done,
    output logic                             wr_error
);

    localparam int                   AW         = C_M_AXI_ADDR_WIDTH;
    localparam int                   DEPTH      = 2 * C_M_AXI_BURST_LEN;
    localparam int                   CW         = $clog2(DEPTH) + 1;
    localparam int                   FIFO_W     = C_M_AXI_DATA_WIDTH + C_M_AXI_DATA_WIDTH/8 + 1;
    localparam logic [CW-1:0]        BL_CNT     = CW'(C_M_AXI_BURST_LEN);
    localparam logic [AW-1:0]        SLOT_BYTES = AW'(C_M_AXI_BURST_LEN * 8);
    localparam logic [AW-1:0]        REGION     = AW'(C_REGION_BYTES);
    localparam logic [AW-1:0]        BASE       = AW'(C_M_TARGET_SLAVE_BASE_ADDR);

    logic [1:0]     state_q,     state_d;
    logic [7:0]     awlen_q,     awlen_d;
    logic [AW-1:0]  awaddr_q,    awaddr_d;
    logic [7:0]     beat_q,      beat_d;
    logic [AW-1:0]  wr_ptr_q,    wr_ptr_d;
    logic           done_q,      done_d;
    logic           err_q,       err_d;
    logic [CW-1:0]  tlast_cnt_q, tlast_cnt_d;
    logic           rdy_en_q;

    fifo_entry_t    fifo_in, fifo_head;
    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           w_valid, w_last, s_ready;
    logic [CW-1:0]  burst_len;
    logic [AW-1:0]  next_ptr;

    // tuser and BID carry nothing this stage needs
    logic           unused_ok;
    assign unused_ok = &{1'b0, m_axi.s_axis_tuser, m_axi.M_AXI_BID};

    assign fifo_in = '{tdata: m_axi.s_axis_tdata, tkeep: m_axi.s_axis_tkeep,
                       tlast: m_axi.s_axis_tlast};

    sync_fifo_fwft #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (M_AXI_ACLK),
        .rst       (M_AXI_ARESET),
        .i_wr_en   (fifo_push),
        .i_wr_data (fifo_in),
        .o_full    (fifo_full),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_head),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    // Stream acceptance and W-channel beat qualification
    always_comb begin
        s_ready   = rdy_en_q && !fifo_full;
        fifo_push = m_axi.s_axis_tvalid && s_ready;
        w_valid   = (state_q == ST_W) && !fifo_empty;
        w_last    = (state_q == ST_W) && (beat_q == awlen_q);
        fifo_pop  = w_valid && m_axi.M_AXI_WREADY;
    end

    // Count of packet ends currently buffered; a nonzero count forces a flush
    always_comb begin
        tlast_cnt_d = tlast_cnt_q;
        if ((fifo_push && fifo_in.tlast) && !(fifo_pop && fifo_head.tlast))
            tlast_cnt_d = tlast_cnt_q + CW'(1);
        else if (!(fifo_push && fifo_in.tlast) && (fifo_pop && fifo_head.tlast))
            tlast_cnt_d = tlast_cnt_q - CW'(1);
    end

    // Burst FSM: IDLE -> AW -> W -> B, one burst outstanding
    always_comb begin
        state_d   = state_q;
        awlen_d   = awlen_q;
        awaddr_d  = awaddr_q;
        beat_d    = beat_q;
        wr_ptr_d  = wr_ptr_q;
        done_d    = 1'b0;
        err_d     = err_q;
        burst_len = (fifo_count >= BL_CNT) ? BL_CNT : fifo_count;
        next_ptr  = wr_ptr_q + SLOT_BYTES;
        case (state_q)
            ST_IDLE: begin
                if (INIT_AXI_TXN && ((fifo_count >= BL_CNT) || (tlast_cnt_q != '0))) begin
                    awlen_d  = 8'(burst_len - CW'(1));
                    awaddr_d = BASE + wr_ptr_q;
                    beat_d   = 8'd0;
                    state_d  = ST_AW;
                end
            end
            ST_AW: begin
                if (m_axi.M_AXI_AWREADY) state_d = ST_W;
            end
            ST_W: begin
                if (fifo_pop) begin
                    beat_d = beat_q + 8'd1;
                    if (w_last) state_d = ST_B;
                end
            end
            ST_B: begin
                if (m_axi.M_AXI_BVALID) begin
                    done_d   = 1'b1;
                    if (m_axi.M_AXI_BRESP != RESP_OKAY) err_d = 1'b1;
                    // A partial burst still consumes the whole slot
                    wr_ptr_d = (next_ptr == REGION) ? '0 : next_ptr;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; tready is held off until the first cycle after reset
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            awlen_q     <= 8'd0;
            awaddr_q    <= '0;
            beat_q      <= 8'd0;
            wr_ptr_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tlast_cnt_q <= '0;
            rdy_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            awlen_q     <= awlen_d;
            awaddr_q    <= awaddr_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tlast_cnt_q <= tlast_cnt_d;
            rdy_en_q    <= 1'b1;
        end
    end

    assign m_axi.s_axis_tready  = s_ready;
    assign m_axi.M_AXI_AWID     = C_M_AXI_ID_WIDTH'(0);
    assign m_axi.M_AXI_AWADDR   = awaddr_q;
    assign m_axi.M_AXI_AWLEN    = awlen_q;
    assign m_axi.M_AXI_AWSIZE   = SIZE_8B;
    assign m_axi.M_AXI_AWBURST  = BURST_INCR;
    assign m_axi.M_AXI_AWLOCK   = 1'b0;
    assign m_axi.M_AXI_AWCACHE  = AWCACHE_DEFAULT;
    assign m_axi.M_AXI_AWPROT   = 4'd0;
    assign m_axi.M_AXI_AWQOS    = 4'd0;
    assign m_axi.M_AXI_AWVALID  = (state_q == ST_AW);
    assign m_axi.M_AXI_WDATA    = fifo_head.tdata;
    assign m_axi.M_AXI_WSTRB    = fifo_head.tkeep;
    assign m_axi.M_AXI_WLAST    = w_last;
    assign m_axi.M_AXI_WVALID   = w_valid;
    assign m_axi.M_AXI_BREADY   = (state_q == ST_B);
    assign wr_ptr               = wr_ptr_q;
    assign burst_done           = done_q;
    assign wr_error             = err_q;

endmodule : axis_to_axifull_wr
`default_nettype wire

// File: tb/tb_axis_to_axifull_wr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_to_axifull_wr
//  Description : Directed self-checking bench. dut1 uses the default 1 MB
//                region, dut2 a 0x100-byte region so slot wrap is visible;
//                both see identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_to_axifull_wr;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct packed { logic [63:0] data; logic [7:0] strb; logic last; } w_t;

    logic        clk = 1'b0;
    logic        rst, init;
    logic        tvalid, tlast;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        awready, wready, bvalid;
    logic [1:0]  bresp;
    logic [31:0] wr_ptr1, wr_ptr2;
    logic        done1, done2, err1, err2;

    int          n_checks = 0;
    int          n_fail   = 0;
    aw_t         aw_q[$];
    w_t          w_q[$];
    logic [31:0] aw2_addr_q[$];
    logic [31:0] ptr2_q[$];
    int          done_cnt;
    int          awv_cycles;

    always #5 clk = ~clk;

    axis_to_axifull_wr_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(64)) bus1 ();
    axis_to_axifull_wr_if #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(64)) bus2 ();

    assign bus1.s_axis_tvalid = tvalid;   assign bus2.s_axis_tvalid = tvalid;
    assign bus1.s_axis_tdata  = tdata;    assign bus2.s_axis_tdata  = tdata;
    assign bus1.s_axis_tkeep  = tkeep;    assign bus2.s_axis_tkeep  = tkeep;
    assign bus1.s_axis_tlast  = tlast;    assign bus2.s_axis_tlast  = tlast;
    assign bus1.s_axis_tuser  = 1'b0;     assign bus2.s_axis_tuser  = 1'b0;
    assign bus1.M_AXI_AWREADY = awready;  assign bus2.M_AXI_AWREADY = awready;
    assign bus1.M_AXI_WREADY  = wready;   assign bus2.M_AXI_WREADY  = wready;
    assign bus1.M_AXI_BVALID  = bvalid;   assign bus2.M_AXI_BVALID  = bvalid;
    assign bus1.M_AXI_BRESP   = bresp;    assign bus2.M_AXI_BRESP   = bresp;
    assign bus1.M_AXI_BID     = 1'b0;     assign bus2.M_AXI_BID     = 1'b0;

    axis_to_axifull_wr #(
        .C_M_TARGET_SLAVE_BASE_ADDR (32'h00000000),
        .C_REGION_BYTES             (32'h00100000),
        .C_M_AXI_BURST_LEN          (16),
        .C_M_AXI_ID_WIDTH           (1),
        .C_M_AXI_ADDR_WIDTH         (32),
        .C_M_AXI_DATA_WIDTH         (64)
    ) dut1 (
        .M_AXI_ACLK (clk), .M_AXI_ARESET (rst), .INIT_AXI_TXN (init),
        .m_axi (bus1), .wr_ptr (wr_ptr1), .burst_done (done1), .wr_error (err1)
    );

    axis_to_axifull_wr #(
        .C_M_TARGET_SLAVE_BASE_ADDR (32'h00000000),
        .C_REGION_BYTES             (32'h00000100),
        .C_M_AXI_BURST_LEN          (16),
        .C_M_AXI_ID_WIDTH           (1),
        .C_M_AXI_ADDR_WIDTH         (32),
        .C_M_AXI_DATA_WIDTH         (64)
    ) dut2 (
        .M_AXI_ACLK (clk), .M_AXI_ARESET (rst), .INIT_AXI_TXN (init),
        .m_axi (bus2), .wr_ptr (wr_ptr2), .burst_done (done2), .wr_error (err2)
    );

    // Bus monitor: record handshakes mid-low-phase, when everything is stable
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.M_AXI_AWVALID) awv_cycles++;
            if (bus1.M_AXI_AWVALID && bus1.M_AXI_AWREADY)
                aw_q.push_back({bus1.M_AXI_AWADDR, bus1.M_AXI_AWLEN});
            if (bus1.M_AXI_WVALID && bus1.M_AXI_WREADY)
                w_q.push_back({bus1.M_AXI_WDATA, bus1.M_AXI_WSTRB, bus1.M_AXI_WLAST});
            if (done1) done_cnt++;
            if (bus2.M_AXI_AWVALID && bus2.M_AXI_AWREADY)
                aw2_addr_q.push_back(bus2.M_AXI_AWADDR);
            if (done2) ptr2_q.push_back(wr_ptr2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hD0D0_0000_0000_0000 | 64'(i);
    endfunction

    function automatic w_t w_at(input int i);
        w_t r = '0;
        if (i < w_q.size()) r = w_q[i];
        return r;
    endfunction

    function automatic aw_t aw_at(input int i);
        aw_t r = '1;
        if (i < aw_q.size()) r = aw_q[i];
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0;
        repeat (3) @(posedge clk);
        #1;
        aw_q.delete(); w_q.delete(); aw2_addr_q.delete(); ptr2_q.delete();
        done_cnt = 0; awv_cycles = 0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t = 0;
        tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
        @(negedge clk);
        while (!bus1.s_axis_tready && t < 1000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 1000) chk("tready_timeout", 64'(t), 64'd0);
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int start, input logic [7:0] last_keep,
                            input logic with_last);
        for (int i = 0; i < n; i++)
            push_beat(pat(start + i), (i == n-1) ? last_keep : 8'hFF, with_last && (i == n-1));
    endtask

    task automatic wait_done(input int n, input string tag);
        int t = 0;
        while (done_cnt < n && t < 2000) begin
            t++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk(tag, 64'(done_cnt), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        w_t  wb;
        aw_t ab;
        int  t;
        rst = 1'b1; init = 1'b1; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = '0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        done_cnt = 0; awv_cycles = 0;

        // Reset values
        @(negedge clk);
        chk("rst_awvalid", 64'(bus1.M_AXI_AWVALID), 64'd0);
        chk("rst_wvalid",  64'(bus1.M_AXI_WVALID),  64'd0);
        chk("rst_wlast",   64'(bus1.M_AXI_WLAST),   64'd0);
        chk("rst_bready",  64'(bus1.M_AXI_BREADY),  64'd0);
        chk("rst_tready",  64'(bus1.s_axis_tready), 64'd0);
        chk("rst_wr_ptr",  64'(wr_ptr1),            64'd0);
        chk("rst_done",    64'(done1),              64'd0);
        chk("rst_error",   64'(err1),               64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("tready_before_first_edge", 64'(bus1.s_axis_tready), 64'd0);
        @(posedge clk); #1;
        chk("tready_after_first_edge", 64'(bus1.s_axis_tready), 64'd1);

        // 32-beat packet -> two full bursts
        do_reset();
        send_pkt(32, 0, 8'hFF, 1'b1);
        wait_done(2, "t1_done_cnt");
        chk("t1_aw_count", 64'(aw_q.size()), 64'd2);
        ab = aw_at(0); chk("t1_awaddr0", 64'(ab.addr), 64'h0);  chk("t1_awlen0", 64'(ab.len), 64'd15);
        ab = aw_at(1); chk("t1_awaddr1", 64'(ab.addr), 64'h80); chk("t1_awlen1", 64'(ab.len), 64'd15);
        chk("t1_w_count", 64'(w_q.size()), 64'd32);
        for (int i = 0; i < 32; i++) begin
            wb = w_at(i);
            chk("t1_wdata", wb.data, pat(i));
            chk("t1_wstrb", 64'(wb.strb), 64'hFF);
            chk("t1_wlast", 64'(wb.last), (i == 15 || i == 31) ? 64'd1 : 64'd0);
        end
        chk("t1_wr_ptr", 64'(wr_ptr1), 64'h100);
        chk("t1_wr_ptr_small_region", 64'(wr_ptr2), 64'h0);

        // 5-beat packet, partial last keep -> short flushed burst
        do_reset();
        send_pkt(5, 100, 8'h0F, 1'b1);
        wait_done(1, "t2_done_cnt");
        ab = aw_at(0);
        chk("t2_awaddr", 64'(ab.addr), 64'h0);
        chk("t2_awlen", 64'(ab.len), 64'd4);
        chk("t2_w_count", 64'(w_q.size()), 64'd5);
        wb = w_at(3); chk("t2_wstrb3", 64'(wb.strb), 64'hFF); chk("t2_wlast3", 64'(wb.last), 64'd0);
        wb = w_at(4); chk("t2_wstrb4", 64'(wb.strb), 64'h0F); chk("t2_wlast4", 64'(wb.last), 64'd1);
        chk("t2_wdata4", wb.data, pat(104));
        chk("t2_wr_ptr", 64'(wr_ptr1), 64'h80);

        // Backpressure: WREADY low fills the FIFO, then drains without loss
        do_reset();
        wready = 1'b0;
        send_pkt(32, 200, 8'hFF, 1'b0);
        @(negedge clk);
        chk("t3_tready_full", 64'(bus1.s_axis_tready), 64'd0);
        chk("t3_nothing_written", 64'(w_q.size()), 64'd0);
        fork
            send_pkt(8, 232, 8'hFF, 1'b1);
            begin
                repeat (6) @(posedge clk);
                chk("t3_tready_still_low", 64'(bus1.s_axis_tready), 64'd0);
                #1 wready = 1'b1;
            end
        join
        wait_done(3, "t3_done_cnt");
        chk("t3_w_count", 64'(w_q.size()), 64'd40);
        for (int i = 0; i < 40; i++) begin
            wb = w_at(i);
            chk("t3_wdata", wb.data, pat(200 + i));
        end
        ab = aw_at(0); chk("t3_awlen0", 64'(ab.len), 64'd15);
        ab = aw_at(1); chk("t3_awlen1", 64'(ab.len), 64'd15);
        ab = aw_at(2); chk("t3_awlen2", 64'(ab.len), 64'd7);
        chk("t3_awaddr2", 64'(ab.addr), 64'h100);

        // 48 beats: small region wraps, large region keeps advancing
        do_reset();
        send_pkt(48, 300, 8'hFF, 1'b1);
        wait_done(3, "t4_done_cnt");
        chk("t4_aw2_count", 64'(aw2_addr_q.size()), 64'd3);
        if (aw2_addr_q.size() == 3) begin
            chk("t4_aw2_addr0", 64'(aw2_addr_q[0]), 64'h0);
            chk("t4_aw2_addr1", 64'(aw2_addr_q[1]), 64'h80);
            chk("t4_aw2_addr2", 64'(aw2_addr_q[2]), 64'h0);
        end
        if (ptr2_q.size() == 3) begin
            chk("t4_ptr2_after1", 64'(ptr2_q[0]), 64'h80);
            chk("t4_ptr2_after2", 64'(ptr2_q[1]), 64'h0);
            chk("t4_ptr2_after3", 64'(ptr2_q[2]), 64'h80);
        end
        ab = aw_at(2); chk("t4_aw1_addr2", 64'(ab.addr), 64'h100);
        chk("t4_wr_ptr1", 64'(wr_ptr1), 64'h180);

        // SLVERR on first burst: sticky error, traffic continues
        do_reset();
        bresp = 2'b10;
        fork
            send_pkt(32, 400, 8'hFF, 1'b1);
            begin
                t = 0;
                while (!done1 && t < 2000) begin
                    t++;
                    @(negedge clk);
                end
                chk("t5_first_done", 64'(done1), 64'd1);
                chk("t5_error_set", 64'(err1), 64'd1);
                @(posedge clk); #1 bresp = 2'b00;
            end
        join
        wait_done(2, "t5_done_cnt");
        chk("t5_error_sticky", 64'(err1), 64'd1);
        chk("t5_wr_ptr", 64'(wr_ptr1), 64'h100);

        // INIT low holds bursts off; reset during W clears everything at once
        init = 1'b0;
        wready = 1'b0;
        awv_cycles = 0;
        send_pkt(16, 500, 8'hFF, 1'b0);
        repeat (10) @(negedge clk);
        chk("t6_no_awvalid", 64'(awv_cycles), 64'd0);
        @(posedge clk); #1 init = 1'b1;
        @(negedge clk);
        chk("t6_awvalid_not_yet", 64'(bus1.M_AXI_AWVALID), 64'd0);
        @(negedge clk);
        chk("t6_awvalid_next", 64'(bus1.M_AXI_AWVALID), 64'd1);
        @(negedge clk);
        chk("t6_wvalid", 64'(bus1.M_AXI_WVALID), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_awvalid", 64'(bus1.M_AXI_AWVALID), 64'd0);
        chk("t6_rst_wvalid",  64'(bus1.M_AXI_WVALID),  64'd0);
        chk("t6_rst_wlast",   64'(bus1.M_AXI_WLAST),   64'd0);
        chk("t6_rst_bready",  64'(bus1.M_AXI_BREADY),  64'd0);
        chk("t6_rst_tready",  64'(bus1.s_axis_tready), 64'd0);
        chk("t6_rst_wr_ptr",  64'(wr_ptr1),            64'd0);
        chk("t6_rst_done",    64'(done1),              64'd0);
        chk("t6_rst_error",   64'(err1),               64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axis_to_axifull_wr
`default_nettype wire
